// File: rtl/controlador_dma.sv
// controlador_dma: word DMA engine that copies a memory region or fills one with a constant
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_start, i_modo          transfer request (sampled when idle), 0=copy 1=fill
//   i_origem, i_destino      source / destination base word addresses
//   i_quantidade, i_valor    word count, fill constant
//   i_abortar                cancel the active transfer
//   o_endereco, o_mem_write  memory address and write strobe
//   o_dado_escrito           memory write data
//   i_dado_lido              memory read data (combinational from o_endereco)
//   o_ocupado, o_concluido   busy flag, one-cycle completion pulse
//   o_restante               words not yet written
module controlador_dma #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_modo,
  input  logic [ADDR_W-1:0] i_origem,
  input  logic [ADDR_W-1:0] i_destino,
  input  logic [LEN_W-1:0]  i_quantidade,
  input  logic [DATA_W-1:0] i_valor,
  input  logic              i_abortar,
  output logic [ADDR_W-1:0] o_endereco,
  output logic              o_mem_write,
  output logic [DATA_W-1:0] o_dado_escrito,
  input  logic [DATA_W-1:0] i_dado_lido,
  output logic              o_ocupado,
  output logic              o_concluido,
  output logic [LEN_W-1:0]  o_restante
);
  typedef enum logic [1:0] {OCIOSO, LER, ESCREVER, FIM} t_estado;
  t_estado           r_estado, w_prox;
  logic [ADDR_W-1:0] r_src, r_dst;
  logic [LEN_W-1:0]  r_restante;
  logic [DATA_W-1:0] r_valor, r_buf;
  logic              r_modo;
  logic              w_ultimo;
  assign w_ultimo = r_restante == LEN_W'(1);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_estado <= OCIOSO;
    else r_estado <= w_prox;
  end
  // abortar overrides every transition out of LER/ESCREVER
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO:   if (i_start) w_prox = (i_quantidade == '0) ? FIM : (i_modo ? ESCREVER : LER);
      LER:      w_prox = i_abortar ? OCIOSO : ESCREVER;
      ESCREVER: w_prox = i_abortar ? OCIOSO : w_ultimo ? FIM : (r_modo ? ESCREVER : LER);
      default:  w_prox = OCIOSO;
    endcase
  end
  // the write in ESCREVER happens even when aborting, so counters still advance
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_src      <= '0;
      r_dst      <= '0;
      r_restante <= '0;
      r_valor    <= '0;
      r_buf      <= '0;
      r_modo     <= 1'b0;
    end else begin
      if (r_estado == OCIOSO && i_start) begin
        r_src      <= i_origem;
        r_dst      <= i_destino;
        r_restante <= i_quantidade;
        r_valor    <= i_valor;
        r_modo     <= i_modo;
      end
      if (r_estado == LER) r_buf <= i_dado_lido;
      if (r_estado == ESCREVER) begin
        r_dst      <= r_dst + ADDR_W'(1);
        r_src      <= r_modo ? r_src : r_src + ADDR_W'(1);
        r_restante <= r_restante - LEN_W'(1);
      end
    end
  end
  assign o_endereco     = (r_estado == LER) ? r_src : (r_estado == ESCREVER) ? r_dst : '0;
  assign o_mem_write    = r_estado == ESCREVER;
  assign o_dado_escrito = (r_estado == ESCREVER) ? (r_modo ? r_valor : r_buf) : '0;
  assign o_ocupado      = r_estado != OCIOSO;
  assign o_concluido    = r_estado == FIM;
  assign o_restante     = r_restante;
endmodule

// File: tb/tb_controlador_dma.sv
// tb_controlador_dma: scoreboard bench for controlador_dma with a 64-word memory model
module tb_controlador_dma;
  logic        clk = 1'b0;
  logic        rst_n, start, modo, abortar;
  logic [25:0] origem, destino;
  logic [15:0] quantidade;
  logic [31:0] valor;
  logic [25:0] endereco;
  logic        mem_write, ocupado, concluido;
  logic [31:0] dado_escrito, dado_lido;
  logic [15:0] restante;
  logic [31:0] mem [64];
  typedef struct {logic [25:0] a; logic [31:0] d;} wr_t;
  wr_t q[$];
  int checks = 0, errors = 0;
  int wr_cnt = 0, conc_cnt = 0, occ_cnt = 0;
  always #5 clk = ~clk;
  controlador_dma dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_modo(modo),
    .i_origem(origem), .i_destino(destino), .i_quantidade(quantidade),
    .i_valor(valor), .i_abortar(abortar), .o_endereco(endereco),
    .o_mem_write(mem_write), .o_dado_escrito(dado_escrito),
    .i_dado_lido(dado_lido), .o_ocupado(ocupado), .o_concluido(concluido),
    .o_restante(restante)
  );
  assign dado_lido = mem[endereco[5:0]];
  always @(posedge clk) if (mem_write) mem[endereco[5:0]] <= dado_escrito;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && mem_write) begin
      wr_cnt++;
      if (q.size() == 0) chk("wr_extra", 1, 0);
      else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_addr", 64'(endereco), 64'(e.a));
        chk("wr_data", 64'(dado_escrito), 64'(e.d));
      end
    end
    if (concluido) conc_cnt++;
    if (ocupado) occ_cnt++;
  end
  task automatic start_xfer(input logic m, input logic [25:0] o, input logic [25:0] d,
                            input logic [15:0] n, input logic [31:0] v, input logic ab);
    @(posedge clk); #2;
    modo = m; origem = o; destino = d; quantidade = n; valor = v; abortar = ab; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; abortar = 1'b0;
  endtask
  task automatic wait_fim(output int n);
    n = 1;
    @(negedge clk);
    while (!concluido && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic clr();
    wr_cnt = 0; conc_cnt = 0; occ_cnt = 0;
  endtask
  initial begin
    int n;
    bit found;
    rst_n = 1'b0; start = 1'b0; modo = 1'b0; abortar = 1'b0;
    origem = '0; destino = '0; quantidade = '0; valor = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    for (int i = 0; i < 8; i++) mem[10+i] = $urandom;
    #3;
    chk("rst_ocupado", 64'(ocupado), 0);
    chk("rst_mem_write", 64'(mem_write), 0);
    chk("rst_restante", 64'(restante), 0);
    chk("rst_endereco", 64'(endereco), 0);
    chk("rst_concluido", 64'(concluido), 0);
    chk("rst_dado", 64'(dado_escrito), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    clr();
    for (int i = 0; i < 4; i++) q.push_back('{26'(40 + i), mem[10+i]});
    start_xfer(1'b0, 26'd10, 26'd40, 16'd4, 32'h0, 1'b0);
    wait_fim(n);
    chk("copy_lat", 64'(n), 9);
    @(negedge clk);
    chk("copy_nwr", 64'(wr_cnt), 4);
    chk("copy_conc", 64'(conc_cnt), 1);
    for (int i = 0; i < 4; i++) chk("copy_mem", 64'(mem[40+i]), 64'(mem[10+i]));
    chk("copy_rest", 64'(restante), 0);
    chk("copy_idle", 64'(ocupado), 0);
    clr();
    for (int i = 0; i < 3; i++) q.push_back('{26'(5 + i), 32'hDEADBEEF});
    start_xfer(1'b1, 26'd0, 26'd5, 16'd3, 32'hDEADBEEF, 1'b1);
    wait_fim(n);
    chk("fill_lat", 64'(n), 4);
    chk("fill_nwr", 64'(wr_cnt), 3);
    for (int i = 0; i < 3; i++) chk("fill_mem", 64'(mem[5+i]), 64'hDEADBEEF);
    @(negedge clk);
    clr();
    start_xfer(1'b0, 26'd10, 26'd40, 16'd0, 32'h0, 1'b0);
    wait_fim(n);
    chk("zero_lat", 64'(n), 1);
    @(negedge clk);
    chk("zero_occ", 64'(occ_cnt), 1);
    chk("zero_nwr", 64'(wr_cnt), 0);
    chk("zero_conc", 64'(conc_cnt), 1);
    clr();
    q.push_back('{26'h3FFFFFF, 32'h12345678});
    q.push_back('{26'h0, 32'h12345678});
    start_xfer(1'b1, 26'd0, 26'h3FFFFFF, 16'd2, 32'h12345678, 1'b0);
    wait_fim(n);
    chk("wrap_lat", 64'(n), 3);
    chk("wrap_nwr", 64'(wr_cnt), 2);
    @(negedge clk);
    clr();
    for (int i = 0; i < 3; i++) q.push_back('{26'(50 + i), mem[10+i]});
    start_xfer(1'b0, 26'd10, 26'd50, 16'd8, 32'h0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (mem_write && wr_cnt == 2) found = 1'b1;
      else begin
        @(posedge clk); #2;
      end
    end
    chk("abort_seen", 64'(found), 1);
    abortar = 1'b1;
    @(posedge clk); #2 abortar = 1'b0;
    chk("abort_idle", 64'(ocupado), 0);
    chk("abort_rest", 64'(restante), 5);
    repeat (4) @(negedge clk);
    chk("abort_nwr", 64'(wr_cnt), 3);
    chk("abort_conc", 64'(conc_cnt), 0);
    chk("abort_rest_hold", 64'(restante), 5);
    clr();
    q.push_back('{26'd20, 32'hCAFE0001});
    start_xfer(1'b1, 26'd0, 26'd20, 16'd1, 32'hCAFE0001, 1'b0);
    wait_fim(n);
    chk("restart_lat", 64'(n), 2);
    chk("restart_mem", 64'(mem[20]), 64'hCAFE0001);
    @(negedge clk);
    q.push_back('{26'd30, 32'h5A5A5A5A});
    start_xfer(1'b1, 26'd0, 26'd30, 16'd4, 32'h5A5A5A5A, 1'b0);
    start = 1'b1; modo = 1'b0; destino = 26'd60; quantidade = 16'd9; valor = 32'h11111111;
    @(posedge clk); #2 start = 1'b0;
    chk("busy_addr", 64'(endereco), 31);
    chk("busy_rest", 64'(restante), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_write", 64'(mem_write), 0);
    chk("arst_ocupado", 64'(ocupado), 0);
    chk("arst_endereco", 64'(endereco), 0);
    chk("arst_restante", 64'(restante), 0);
    chk("arst_dado", 64'(dado_escrito), 0);
    @(posedge clk); #2;
    chk("arst_mem31", 64'(mem[31]), 0);
    chk("arst_mem30", 64'(mem[30]), 64'h5A5A5A5A);
    rst_n = 1'b1;
    @(negedge clk);
    chk("queue_empty", 64'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/controlador_dma.md
CONTROLADOR_DMA -- requirements
Module: controlador_dma

Interface
REQ-001 Parameters: ADDR_W, default 26, memory word-address width; DATA_W, default 32, memory word width; LEN_W, default 16, transfer-length width.
REQ-002 clock  input  1  single clock, all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a transfer; sampled only in OCIOSO.
REQ-005 modo  input  1  transfer mode: 0 = copy, 1 = fill.
REQ-006 origem  input  ADDR_W  copy source base address; captured at start.
REQ-007 destino  input  ADDR_W  destination base address; captured at start.
REQ-008 quantidade  input  LEN_W  word count; captured at start.
REQ-009 valor  input  DATA_W  fill constant; captured at start.
REQ-010 abortar  input  1  cancel the active transfer.
REQ-011 endereco  output  ADDR_W  word address driven to data memory.
REQ-012 memWrite  output  1  memory write strobe; memory writes on the rising edge while high.
REQ-013 dado_Escrito  output  DATA_W  data driven to memory.
REQ-014 dado_Lido  input  DATA_W  memory read data, combinational from endereco in the same cycle.
REQ-015 ocupado  output  1  high in every state except OCIOSO.
REQ-016 concluido  output  1  one-cycle pulse on normal completion.
REQ-017 restante  output  LEN_W  words not yet written.

Function
REQ-018 States: OCIOSO, LER, ESCREVER, FIM; encoding is free.
REQ-019 OCIOSO with start=1: capture origem, destino, quantidade, valor and modo; restante<=quantidade; go to FIM if quantidade=0, else LER if modo=0, else ESCREVER.
REQ-020 LER (copy only): endereco=src pointer, memWrite=0; on the edge, buffer<=dado_Lido, go to ESCREVER.
REQ-021 ESCREVER: endereco=dst pointer, memWrite=1, dado_Escrito=buffer (copy) or captured valor (fill); on the edge, dst+1, src+1 (copy only), restante-1.
REQ-022 ESCREVER exit: if restante was 1, go to FIM; otherwise go to LER (copy) or stay in ESCREVER (fill).
REQ-023 FIM: concluido=1 for exactly this cycle; next state OCIOSO.
REQ-024 Throughput: copy takes 2 cycles per word; fill takes 1 cycle per word; start-to-concluido latency is 2N+1 cycles (copy) or N+1 cycles (fill), N>0.
REQ-025 memWrite is decoded from the state register only: high exactly in ESCREVER, never glitching in other states.
REQ-026 In OCIOSO and FIM: endereco=0, dado_Escrito=0, memWrite=0.
REQ-027 Pointer arithmetic is modulo 2^ADDR_W; address 2^ADDR_W-1 wraps to 0 without error.
REQ-028 start asserted while ocupado=1 is ignored and has no effect on the active transfer.
REQ-029 abortar=1 in LER or ESCREVER: go to OCIOSO on the next edge, with no concluido pulse; abortar has priority over the ESCREVER write-path transition, but the write in that ESCREVER cycle still occurs.
REQ-030 abortar in OCIOSO or FIM has no effect; abortar and start both high in OCIOSO: start wins.
REQ-031 Overlapping source and destination regions are copied in ascending address order with no hazard protection.
REQ-032 restante holds its last value in OCIOSO: 0 after completion, remaining count after abort.

Reset
REQ-033 reset=0 forces, immediately and regardless of clock: state=OCIOSO, memWrite=0, ocupado=0, concluido=0, restante=0, endereco=0, dado_Escrito=0, and all pointers and the buffer to 0.
REQ-034 Reset mid-transfer terminates it with no further memory write and no concluido; operation resumes on the first edge after reset=1.

Verification
REQ-035 Copy: mem[10..13]={A,B,C,D}, start origem=10 destino=40 quantidade=4 -> mem[40..43]={A,B,C,D}; concluido pulses 9 cycles after start; memWrite high for 4 cycles total.
REQ-036 Fill: valor=0xDEADBEEF, destino=5, quantidade=3 -> mem[5..7]=0xDEADBEEF; memWrite high for 3 consecutive cycles; concluido on cycle 4.
REQ-037 Zero length: quantidade=0 -> no memWrite; concluido pulses on the cycle after start; ocupado is high for 1 cycle.
REQ-038 Wrap: destino=2^26-1, fill quantidade=2 -> writes to address 0x3FFFFFF and then 0x0000000.
REQ-039 Abort: copy quantidade=8, abortar during the 3rd ESCREVER -> exactly 3 words written; restante=5; no concluido; a new start is accepted.
REQ-040 Reset mid-fill: reset=0 while memWrite=1 -> memWrite drops asynchronously; the destination word is unchanged at the following edge; start while busy (REQ-028) is checked in the same run.
